if_fetch_unit: RTL and testbench

- Instruction-fetch stage; the producing end of the IF→ID handshake. It generates the pc/inst pair that the IF/ID register hands to the decode stage.
- Fetches 32-bit instructions over the byte-wide memory-controller port, four little-endian byte reads per instruction.
- Caches fetched words in a small direct-mapped instruction cache.
- Honours the decode-stage stall and EX-stage branch/jump redirects.

---
 rtl/if_fetch_unit_pkg.sv | 16 +
 rtl/if_fetch_unit_icache_dm.sv | 51 +++++
 rtl/if_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared widths and constants
// for the instruction-fetch stage
package if_fetch_unit_pkg;

  localparam int AddrBus = 32;
  localparam int InstBus = 32;

  localparam logic [31:0] ZeroWord = 32'h0;
  localparam logic        Enable   = 1'b1;
  localparam logic        Disable  = 1'b0;

  localparam logic [1:0] LOOKUP  = 2'd0;
  localparam logic [1:0] MISS    = 2'd1;
  localparam logic [1:0] DELIVER = 2'd2;

endpackage

// File: rtl/if_fetch_unit_icache_dm.sv
// icache_dm: direct-mapped one-word-line icache
// combinational read, single write port, async clear
module icache_dm
  import if_fetch_unit_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = AddrBus - IDX_W - 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               rd_hit,
  output logic [InstBus-1:0] rd_data,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [InstBus-1:0] wr_data
);

  localparam int Lines = 1 << IDX_W;

  logic [Lines-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [Lines];
  logic [InstBus-1:0] data_q [Lines];

  assign rd_hit  = valid_q[rd_idx]
                && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx];

  // mark a line valid when it is filled
  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = Enable;
  end

  // valid bits clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // tag/data arrays need no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage, byte-serial miss fill,
// direct-mapped icache, stall and redirect handling
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [AddrBus-1:0] RESET_PC     = 32'h0,
  parameter int                 ICACHE_IDX_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               id_stall,
  input  logic               jump_en,
  input  logic [AddrBus-1:0] jump_addr,
  input  logic               mem_byte_valid,
  input  logic [7:0]         mem_byte,
  output logic               mem_req,
  output logic [AddrBus-1:0] mem_addr,
  output logic [AddrBus-1:0] pc_o,
  output logic [InstBus-1:0] inst_o,
  output logic               inst_valid_o
);

  localparam int TagW = AddrBus - ICACHE_IDX_W - 2;

  logic [AddrBus-1:0] pc_q, pc_d;
  logic [1:0]         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [InstBus-1:0] line_q, line_d;
  logic               mem_req_q, mem_req_d;
  logic [AddrBus-1:0] mem_addr_q, mem_addr_d;
  logic [AddrBus-1:0] pc_o_q, pc_o_d;
  logic [InstBus-1:0] inst_q, inst_d;
  logic               valid_q, valid_d;
  logic               drop_q, drop_d;

  logic               hit;
  logic [InstBus-1:0] hit_data;
  logic               wr_en;
  logic               byte_acc;
  logic               st_lookup;
  logic               st_miss;
  logic [ICACHE_IDX_W-1:0] idx;
  logic [TagW-1:0]    tag;

  assign idx       = pc_q[ICACHE_IDX_W+1:2];
  assign tag       = pc_q[AddrBus-1:ICACHE_IDX_W+2];
  assign byte_acc  = mem_byte_valid && !drop_q;
  assign st_lookup = (state_q == LOOKUP);
  assign st_miss   = (state_q == MISS);

  icache_dm #(
    .IDX_W (ICACHE_IDX_W)
  ) u_icache (
    .clk     (clk),
    .rst_n   (rst),
    .rd_idx  (idx),
    .rd_tag  (tag),
    .rd_hit  (hit),
    .rd_data (hit_data),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_tag  (tag),
    .wr_data ({mem_byte, line_q[23:0]})
  );

  // next-state: rdy gates everything, jump beats stall
  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    pc_o_d     = pc_o_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    drop_d     = drop_q;
    wr_en      = Disable;
    if (rdy) begin
      if (mem_byte_valid && drop_q) drop_d = Disable;
      if (jump_en) begin
        pc_d      = jump_addr;
        state_d   = LOOKUP;
        valid_d   = Disable;
        mem_req_d = Disable;
        cnt_d     = '0;
        // a byte still owed by memory must be discarded
        drop_d    = (drop_q || mem_req_q)
                 && !mem_byte_valid;
      end else begin
        unique case (1'b1)
          st_lookup: begin
            if (!id_stall) begin
              if (hit) begin
                inst_d  = hit_data;
                pc_o_d  = pc_q;
                valid_d = Enable;
                pc_d    = pc_q + 32'd4;
              end else begin
                mem_req_d  = Enable;
                mem_addr_d = pc_q;
                cnt_d      = '0;
                valid_d    = Disable;
                state_d    = MISS;
              end
            end
          end
          st_miss: begin
            if (byte_acc) begin
              line_d[{cnt_q[1:0], 3'b000} +: 8] = mem_byte;
              cnt_d      = cnt_q + 3'd1;
              mem_addr_d = pc_q + 32'(cnt_q) + 32'd1;
              if (cnt_q == 3'd3) begin
                mem_req_d = Disable;
                wr_en     = Enable;
                state_d   = DELIVER;
              end
            end
          end
          default: begin
            if (!id_stall) begin
              inst_d  = line_q;
              pc_o_d  = pc_q;
              valid_d = Enable;
              pc_d    = pc_q + 32'd4;
              state_d = LOOKUP;
            end
          end
        endcase
      end
    end
  end

  // stage registers, async active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      state_q    <= LOOKUP;
      cnt_q      <= '0;
      line_q     <= ZeroWord;
      mem_req_q  <= Disable;
      mem_addr_q <= ZeroWord;
      pc_o_q     <= ZeroWord;
      inst_q     <= ZeroWord;
      valid_q    <= Disable;
      drop_q     <= Disable;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      pc_o_q     <= pc_o_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign pc_o         = pc_o_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenarios, then random
// stimulus against a program-order fetch model
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        id_stall;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        mem_byte_valid;
  logic [7:0]  mem_byte;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem_arr [4096];
  bit          busy;
  int          lat_cnt;
  int          fix_lat;
  bit          rnd_lat;
  logic [31:0] req_a;
  logic [31:0] addr_log [$];

  bit          model_on;
  logic [31:0] mpc, e_pc, e_inst;
  logic        e_valid;
  int          idle_cnt;
  bit          gave_up;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .id_stall       (id_stall),
    .jump_en        (jump_en),
    .jump_addr      (jump_addr),
    .mem_byte_valid (mem_byte_valid),
    .mem_byte       (mem_byte),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .pc_o           (pc_o),
    .inst_o         (inst_o),
    .inst_valid_o   (inst_valid_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    if (a < 32'd4096) return mem_arr[a[11:0]];
    return a[7:0] ^ a[23:16] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {byte_at(a + 32'd3), byte_at(a + 32'd2),
            byte_at(a + 32'd1), byte_at(a)};
  endfunction

  task automatic mem_tick();
    if (!rst) begin
      busy = 0;
      mem_byte_valid = 1'b0;
      return;
    end
    if (mem_byte_valid && rdy) begin
      mem_byte_valid = 1'b0;
      busy = 0;
    end else if (busy && !mem_byte_valid) begin
      if (lat_cnt == 0) begin
        mem_byte_valid = 1'b1;
        mem_byte = byte_at(req_a);
      end else begin
        lat_cnt--;
      end
    end
    if (!busy && mem_req) begin
      busy = 1;
      req_a = mem_addr;
      lat_cnt = rnd_lat ? int'($urandom_range(0, 2)) : fix_lat;
      addr_log.push_back(mem_addr);
    end
  endtask

  task automatic model_tick();
    logic [31:0] w;
    if (!rdy || (id_stall && !jump_en)) begin
      check("hold_pc", pc_o, e_pc);
      check("hold_inst", inst_o, e_inst);
      check("hold_vld", inst_valid_o, e_valid);
      idle_cnt++;
    end else if (jump_en) begin
      check("jmp_vld", inst_valid_o, 1'b0);
      e_valid = 1'b0;
      mpc = jump_addr;
      idle_cnt++;
    end else if (inst_valid_o) begin
      w = word_at(mpc);
      check("rnd_pc", pc_o, mpc);
      check("rnd_inst", inst_o, w);
      e_pc = mpc;
      e_inst = w;
      e_valid = 1'b1;
      mpc = mpc + 32'd4;
      idle_cnt = 0;
    end else begin
      e_valid = 1'b0;
      idle_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_tick();
    if (model_on) model_tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r;
    for (int i = 0; i < 4096; i++) mem_arr[i] = 8'($urandom);
    mem_arr[0] = 8'h13;
    mem_arr[1] = 8'h05;
    mem_arr[2] = 8'h50;
    mem_arr[3] = 8'h00;
    rst = 1'b0; rdy = 1'b1; id_stall = 1'b0;
    jump_en = 1'b0; jump_addr = '0;
    mem_byte_valid = 1'b0; mem_byte = '0;
    busy = 0; fix_lat = 0; rnd_lat = 0;
    model_on = 0; gave_up = 0; idle_cnt = 0;

    tick(); tick();
    check("rst_req", mem_req, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_inst", inst_o, 32'h0);
    check("rst_vld", inst_valid_o, 1'b0);
    rst = 1'b1;
    addr_log.delete();

    // cold start miss, one-cycle byte latency
    for (int i = 0; i < 60 && !inst_valid_o; i++) tick();
    check("cold_vld", inst_valid_o, 1'b1);
    check("cold_nreq", addr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      a = (i < addr_log.size()) ? addr_log[i] : 32'hFFFF_FFFF;
      check("cold_addr", a, i);
    end
    check("cold_inst", inst_o, 32'h00500513);
    check("cold_pc", pc_o, 32'h0);
    tick();
    check("cold_pulse", inst_valid_o, 1'b0);

    // loop back to 0 while pc 4 has a byte in flight
    jump_en = 1'b1; jump_addr = 32'h0;
    tick();
    jump_en = 1'b0;
    tick();
    check("hit_vld", inst_valid_o, 1'b1);
    check("hit_inst", inst_o, 32'h00500513);
    check("hit_pc", pc_o, 32'h0);
    check("hit_noreq", mem_req, 1'b0);

    // stall held in DELIVER for pc 4
    for (int i = 0; i < 20 && !mem_req; i++) tick();
    for (int i = 0; i < 60 && mem_req; i++) tick();
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stl_vld", inst_valid_o, 1'b0);
      check("stl_pc", pc_o, 32'h0);
      check("stl_inst", inst_o, 32'h00500513);
    end
    id_stall = 1'b0;
    tick();
    check("stl_rel_vld", inst_valid_o, 1'b1);
    check("stl_rel_pc", pc_o, 32'h4);
    check("stl_rel_inst", inst_o, word_at(32'h4));

    // abort pc 8 after two bytes, stray byte late
    fix_lat = 1;
    for (int i = 0; i < 60 && mem_addr != 32'd10; i++) tick();
    jump_en = 1'b1; jump_addr = 32'h100;
    tick();
    jump_en = 1'b0;
    check("jmp_req0", mem_req, 1'b0);
    check("jmp_vld0", inst_valid_o, 1'b0);
    tick();
    check("jmp_req1", mem_req, 1'b1);
    check("jmp_addr", mem_addr, 32'h100);
    for (int i = 0; i < 80 && !inst_valid_o; i++) tick();
    check("jmp_dvld", inst_valid_o, 1'b1);
    check("jmp_dpc", pc_o, 32'h100);
    check("jmp_dinst", inst_o, word_at(32'h100));

    // jump together with stall, then pc 8 must miss
    jump_en = 1'b1; jump_addr = 32'h8; id_stall = 1'b1;
    tick();
    check("js_vld", inst_valid_o, 1'b0);
    jump_en = 1'b0; id_stall = 1'b0;
    tick();
    check("js_req", mem_req, 1'b1);
    check("js_addr", mem_addr, 32'h8);

    // async reset in the middle of a miss
    tick(); tick();
    #2;
    rst = 1'b0;
    #1;
    check("arst_req", mem_req, 1'b0);
    check("arst_addr", mem_addr, 32'h0);
    check("arst_pc", pc_o, 32'h0);
    check("arst_inst", inst_o, 32'h0);
    check("arst_vld", inst_valid_o, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check("arst_miss", mem_req, 1'b1);
    check("arst_maddr", mem_addr, 32'h0);

    // random phase
    mpc = 32'h0; e_pc = '0; e_inst = '0; e_valid = 1'b0;
    idle_cnt = 0; rnd_lat = 1; model_on = 1;
    for (int c = 0; c < 4000 && !gave_up; c++) begin
      rdy      = ($urandom_range(0, 9) != 0);
      id_stall = ($urandom_range(0, 3) == 0);
      jump_en  = ($urandom_range(0, 49) == 0);
      r = int'($urandom_range(0, 9));
      if (r == 0)      jump_addr = 32'hFFFF_FFF8;
      else if (r == 1) jump_addr = $urandom & 32'hFFFF_FFFC;
      else             jump_addr = 32'($urandom_range(0, 127)) << 2;
      tick();
      if (idle_cnt > 400) begin
        n_cmp++;
        n_bad++;
        $display("FAIL fetch_timeout: %0d idle cycles, want <= 400",
                 idle_cnt);
        gave_up = 1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
